// File: rtl/mips_pkg.sv
// Shared MIPS definitions: HI/LO unit control codes, FSM state encoding and operand helpers.
package mips_pkg;

    localparam logic [3:0] ALU_MULU = 4'b1100;
    localparam logic [3:0] ALU_DIVU = 4'b1101;
    localparam logic [3:0] ALU_MULT = 4'b1110;
    localparam logic [3:0] ALU_DIV  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PREP = 2'b01,
        ST_CALC = 2'b10,
        ST_FIX  = 2'b11
    } mdState_e;

    function automatic logic [31:0] absVal(input logic [31:0] v, input logic isSigned);
        if (isSigned && v[31]) begin
            return 32'd0 - v;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/hilo_mul_div_if.sv
// Issue/readback bus between the EX stage and the HI/LO multiply-divide unit.
interface hilo_mul_div_if;
    logic        start;
    logic [3:0]  con;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        hiloR;
    logic        hiloS;
    logic [31:0] hilo_out;
    logic        busy;
    logic        stall;
    logic        done;
    logic        div_zero;

    modport master (
        output start, con, a, b, flush, hiloR, hiloS,
        input  hilo_out, busy, stall, done, div_zero
    );

    modport slave (
        input  start, con, a, b, flush, hiloR, hiloS,
        output hilo_out, busy, stall, done, div_zero
    );
endinterface

// File: rtl/muldiv_core.sv
// Iteration datapath: shift-add multiply / restoring divide on a shared 64-bit accumulator.
// acc holds {HI-partial, LO-partial} for multiply and {remainder, quotient} for divide.
module muldiv_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic        fastLoad,
    input  logic        isDiv,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    output logic [63:0] acc,
    output logic        last
);
    logic [63:0] acc_r;
    logic [31:0] mcand_r;
    logic [5:0]  cnt_r;
    logic [32:0] mulSum_s;
    logic [63:0] mulNext_s;
    logic [32:0] divShift_s;
    logic [33:0] divTrial_s;
    logic [63:0] divNext_s;

    // Next accumulator value for one multiply step and one divide step
    always_comb begin
        mulSum_s   = {1'b0, acc_r[63:32]} + {1'b0, mcand_r};
        divShift_s = acc_r[63:31];
        divTrial_s = {1'b0, divShift_s} - {2'b00, mcand_r};
        if (acc_r[0]) begin
            mulNext_s = {mulSum_s, acc_r[31:1]};
        end else begin
            mulNext_s = {1'b0, acc_r[63:1]};
        end
        // A clear borrow bit means the divisor fitted into the shifted remainder
        if (!divTrial_s[33]) begin
            divNext_s = {divTrial_s[31:0], acc_r[30:0], 1'b1};
        end else begin
            divNext_s = {divShift_s[31:0], acc_r[30:0], 1'b0};
        end
    end

    // Accumulator, multiplicand/divisor and iteration counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r   <= 64'd0;
            mcand_r <= 32'd0;
            cnt_r   <= 6'd0;
        end else if (load) begin
            acc_r   <= {32'd0, opA};
            mcand_r <= opB;
            cnt_r   <= 6'd0;
        end else if (step) begin
            acc_r   <= isDiv ? divNext_s : mulNext_s;
            cnt_r   <= cnt_r + 6'd1;
        end else if (fastLoad) begin
            acc_r   <= 64'(acc_r[31:0]) * 64'(mcand_r);
        end
    end

    assign acc  = acc_r;
    assign last = (cnt_r == 6'd31);

endmodule

// File: rtl/hilo_mul_div.sv
// MIPS HI/LO multiply/divide unit: FSM, sign handling and HI/LO registers around muldiv_core.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiply (divide stays iterative).
module hilo_mul_div
    import mips_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    hilo_mul_div_if.slave bus
);
    mdState_e    state_r;
    logic [1:0]  op_r;
    logic [31:0] rawA_r;
    logic [31:0] rawB_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        negRes_r;
    logic        negRem_r;
    logic        divZero_r;
    logic        busy_r;
    logic        done_r;
    logic        doneZero_r;
    logic        fastRdy_r;

    logic        isDiv_s;
    logic        isSigned_s;
    logic        fastMul_s;
    logic        load_s;
    logic        step_s;
    logic        fastLoad_s;
    logic        last_s;
    logic [63:0] acc_s;
    logic [63:0] prodFix_s;
    logic [31:0] quoFix_s;
    logic [31:0] remFix_s;

    assign isDiv_s    = op_r[0];
    assign isSigned_s = op_r[1];

`ifdef MULDIV_FAST_MUL_EN
    assign fastMul_s = ~op_r[0];
`else
    assign fastMul_s = 1'b0;
`endif

    muldiv_core u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_s),
        .step     (step_s),
        .fastLoad (fastLoad_s),
        .isDiv    (isDiv_s),
        .opA      (absVal(rawA_r, isSigned_s)),
        .opB      (absVal(rawB_r, isSigned_s)),
        .acc      (acc_s),
        .last     (last_s)
    );

    // Core control decoded from the current state
    always_comb begin
        load_s     = 1'b0;
        step_s     = 1'b0;
        fastLoad_s = 1'b0;
        case (state_r)
            ST_PREP: load_s     = 1'b1;
            ST_CALC: step_s     = 1'b1;
            ST_FIX:  fastLoad_s = fastMul_s & ~fastRdy_r;
            default: load_s     = 1'b0;
        endcase
    end

    // Sign correction of the magnitude result; negation of 0x80000000 wraps to itself
    always_comb begin
        if (negRes_r) begin
            prodFix_s = 64'd0 - acc_s;
            quoFix_s  = 32'd0 - acc_s[31:0];
        end else begin
            prodFix_s = acc_s;
            quoFix_s  = acc_s[31:0];
        end
        if (negRem_r) begin
            remFix_s = 32'd0 - acc_s[63:32];
        end else begin
            remFix_s = acc_s[63:32];
        end
    end

    // Operation FSM with HI/LO write-back and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            op_r       <= 2'b00;
            rawA_r     <= 32'd0;
            rawB_r     <= 32'd0;
            hi_r       <= 32'd0;
            lo_r       <= 32'd0;
            negRes_r   <= 1'b0;
            negRem_r   <= 1'b0;
            divZero_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            doneZero_r <= 1'b0;
            fastRdy_r  <= 1'b0;
        end else begin
            done_r     <= 1'b0;
            doneZero_r <= 1'b0;
            if (bus.flush) begin
                state_r   <= ST_IDLE;
                busy_r    <= 1'b0;
                fastRdy_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (bus.start && (bus.con[3:2] == 2'b11)) begin
                            op_r    <= bus.con[1:0];
                            rawA_r  <= bus.a;
                            rawB_r  <= bus.b;
                            busy_r  <= 1'b1;
                            state_r <= ST_PREP;
                        end
                    end
                    ST_PREP: begin
                        negRes_r  <= isSigned_s & (rawA_r[31] ^ rawB_r[31]);
                        negRem_r  <= isSigned_s & rawA_r[31];
                        divZero_r <= isDiv_s & (rawB_r == 32'd0);
                        fastRdy_r <= 1'b0;
                        if ((isDiv_s && (rawB_r == 32'd0)) || fastMul_s) begin
                            state_r <= ST_FIX;
                        end else begin
                            state_r <= ST_CALC;
                        end
                    end
                    ST_CALC: begin
                        if (last_s) begin
                            state_r <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        if (fastMul_s && !fastRdy_r) begin
                            fastRdy_r <= 1'b1;
                        end else begin
                            if (divZero_r) begin
                                lo_r <= 32'hFFFF_FFFF;
                                hi_r <= rawA_r;
                            end else if (isDiv_s) begin
                                lo_r <= quoFix_s;
                                hi_r <= remFix_s;
                            end else begin
                                lo_r <= prodFix_s[31:0];
                                hi_r <= prodFix_s[63:32];
                            end
                            done_r     <= 1'b1;
                            doneZero_r <= divZero_r;
                            busy_r     <= 1'b0;
                            state_r    <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.hilo_out = bus.hiloS ? hi_r : lo_r;
    assign bus.busy     = busy_r;
    assign bus.stall    = busy_r & (bus.hiloR | bus.start);
    assign bus.done     = done_r;
    assign bus.div_zero = doneZero_r;

endmodule

// File: tb/tb_hilo_mul_div.sv
// Randomized self-checking bench for hilo_mul_div against an arithmetic reference model.
// Honors MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_hilo_mul_div;
    import mips_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   nChecks = 0;
    int   nErrors = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 3;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT  = 34;
    localparam int HR_START = (MUL_LAT > 5) ? 5 : 1;

    hilo_mul_div_if bus();

    hilo_mul_div dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference results straight from MIPS arithmetic rules
    task automatic refModel(input logic [3:0] con, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        logic [63:0] p;
        longint      sa, sb;
        int          qa, qb;
        dz = 1'b0;
        if (!con[0]) begin
            if (con[1]) begin
                sa = longint'(signed'(a));
                sb = longint'(signed'(b));
                p  = sa * sb;
            end else begin
                p = {32'd0, a} * {32'd0, b};
            end
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            dz = 1'b1;
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else if (!con[1]) begin
            lo = a / b;
            hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lo = 32'h8000_0000;
            hi = 32'd0;
        end else begin
            qa = signed'(a);
            qb = signed'(b);
            lo = 32'(qa / qb);
            hi = 32'(qa % qb);
        end
    endtask

    task automatic readHiLo(output logic [31:0] hi, output logic [31:0] lo);
        bus.hiloS = 1'b1;
        #1 hi = bus.hilo_out;
        bus.hiloS = 1'b0;
        #1 lo = bus.hilo_out;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic issue(input logic [3:0] con, input logic [31:0] a, input logic [31:0] b);
        bus.con   = con;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom();
        bus.b     = $urandom();
    endtask

    task automatic waitDone(output int lat);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic runCheck(input string tag, input logic [3:0] con, input logic [31:0] a,
                            input logic [31:0] b, input int expLat);
        logic [31:0] eHi, eLo, gHi, gLo;
        logic        eDz;
        int          lat;
        refModel(con, a, b, eHi, eLo, eDz);
        issue(con, a, b);
        checkVal({tag, "_busy"}, 64'(bus.busy), 64'd1);
        waitDone(lat);
        if (expLat > 0) begin
            checkVal({tag, "_latency"}, 64'(lat), 64'(expLat));
        end else begin
            checkVal({tag, "_done_seen"}, 64'(lat > 0), 64'd1);
        end
        checkVal({tag, "_div_zero"}, 64'(bus.div_zero), 64'(eDz));
        readHiLo(gHi, gLo);
        checkVal({tag, "_hi"}, 64'(gHi), 64'(eHi));
        checkVal({tag, "_lo"}, 64'(gLo), 64'(eLo));
        @(negedge clk);
        checkVal({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    // Aborts a divide at CALC iteration 10 by flush (useReset=0) or reset (useReset=1)
    task automatic abortTest(input logic useReset, input logic [31:0] expHi, input logic [31:0] expLo);
        logic [31:0] gHi, gLo;
        int          doneSeen;
        string       tag;
        tag = useReset ? "rst" : "flush";
        issue(ALU_DIVU, $urandom(), 32'd3 + 32'($urandom_range(0, 1000)));
        repeat (10) @(negedge clk);
        if (useReset) begin
            rst_n = 1'b0;
            #1 checkVal({tag, "_busy_in_reset"}, 64'(bus.busy), 64'd0);
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            bus.flush = 1'b1;
            @(negedge clk);
            bus.flush = 1'b0;
        end
        checkVal({tag, "_busy"}, 64'(bus.busy), 64'd0);
        doneSeen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) doneSeen++;
        end
        checkVal({tag, "_no_done"}, 64'(doneSeen), 64'd0);
        readHiLo(gHi, gLo);
        checkVal({tag, "_hi_kept"}, 64'(gHi), 64'(expHi));
        checkVal({tag, "_lo_kept"}, 64'(gLo), 64'(expLo));
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] eHi, eLo, gHi, gLo, ra, rb;
        logic [3:0]  rc;
        logic        eDz;
        int          lat, el;

        bus.start = 1'b0;
        bus.con   = 4'd0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.flush = 1'b0;
        bus.hiloR = 1'b0;
        bus.hiloS = 1'b0;

        // Reset state, with start and hiloR asserted to show stall stays low
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.con   = ALU_MULT;
        bus.hiloR = 1'b1;
        #1;
        checkVal("reset_busy", 64'(bus.busy), 64'd0);
        checkVal("reset_stall", 64'(bus.stall), 64'd0);
        checkVal("reset_done", 64'(bus.done), 64'd0);
        checkVal("reset_div_zero", 64'(bus.div_zero), 64'd0);
        readHiLo(gHi, gLo);
        checkVal("reset_hi", 64'(gHi), 64'd0);
        checkVal("reset_lo", 64'(gLo), 64'd0);
        bus.start = 1'b0;
        bus.hiloR = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        runCheck("mult_neg", ALU_MULT, 32'hFFFF_FFFE, 32'd3, MUL_LAT);
        runCheck("multu_max", ALU_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        runCheck("div_neg", ALU_DIV, 32'hFFFF_FFF9, 32'd2, DIV_LAT);
        runCheck("divu_zero", ALU_DIVU, 32'd10, 32'd0, -1);
        runCheck("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT);
        runCheck("div_zero_s", ALU_DIV, 32'h8000_0005, 32'd0, -1);

        // Non-HI/LO control codes must not start an operation
        bus.con   = 4'b0110;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checkVal("ignored_con_busy", 64'(bus.busy), 64'd0);

        // A start while busy is stalled and dropped
        refModel(ALU_DIV, 32'h0001_2345, 32'hFFFF_FF00, eHi, eLo, eDz);
        issue(ALU_DIV, 32'h0001_2345, 32'hFFFF_FF00);
        repeat (4) @(negedge clk);
        bus.con   = ALU_MULT;
        bus.a     = 32'd77;
        bus.b     = 32'd99;
        bus.start = 1'b1;
        #1 checkVal("busy_start_stall", 64'(bus.stall), 64'd1);
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(lat);
        checkVal("busy_start_done_seen", 64'(lat > 0), 64'd1);
        readHiLo(gHi, gLo);
        checkVal("busy_start_hi", 64'(gHi), 64'(eHi));
        checkVal("busy_start_lo", 64'(gLo), 64'(eLo));
        @(negedge clk);

        // mfhi held from early in a multiply: stall until the done cycle
        refModel(ALU_MULT, 32'h7654_3210, 32'h8000_0003, eHi, eLo, eDz);
        issue(ALU_MULT, 32'h7654_3210, 32'h8000_0003);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == HR_START) begin
                bus.hiloR = 1'b1;
                bus.hiloS = 1'b1;
            end
            #1;
            if (k >= HR_START) begin
                if (bus.done) begin
                    lat = k;
                    checkVal("hiloR_stall_done", 64'(bus.stall), 64'd0);
                    checkVal("hiloR_hi", 64'(bus.hilo_out), 64'(eHi));
                    break;
                end else begin
                    checkVal("hiloR_stall", 64'(bus.stall), 64'd1);
                end
            end
        end
        checkVal("hiloR_latency", 64'(lat), 64'(MUL_LAT));
        bus.hiloR = 1'b0;
        bus.hiloS = 1'b0;
        @(negedge clk);

        // Flush keeps prior HI/LO; reset clears them
        refModel(ALU_MULU, 32'h1234_5678, 32'h9ABC_DEF0, eHi, eLo, eDz);
        runCheck("pre_abort", ALU_MULU, 32'h1234_5678, 32'h9ABC_DEF0, MUL_LAT);
        abortTest(1'b0, eHi, eLo);
        abortTest(1'b1, 32'd0, 32'd0);

        // Randomized operations across all four codes and edge operands
        for (int i = 0; i < 24; i++) begin
            rc = {2'b11, 2'($urandom_range(0, 3))};
            ra = $urandom();
            rb = $urandom();
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       ra = 32'h8000_0000;
                3:       rb = 32'hFFFF_FFFF;
                default: ra = ra;
            endcase
            if (!rc[0]) begin
                el = MUL_LAT;
            end else if (rb == 32'd0) begin
                el = -1;
            end else begin
                el = DIV_LAT;
            end
            runCheck($sformatf("rand%0d", i), rc, ra, rb, el);
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
